mac_lanes: RTL

- Multi-lane signed multiply-accumulate engine: the parametrised successor of the single MAC.
- One broadcast activation is multiplied by LANES per-lane weights each accepted beat. Each lane accumulates for a programmable number of beats, then requantises (arithmetic right shift, saturate, optional ReLU).
- Results are presented over a valid/ready output handshake.
- Sits between the activation/weight feeders and the layer output buffer; computes LANES neurons of a dense layer in parallel.

---
 rtl/mac_lanes.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/mac_lanes.sv
// Multi-lane signed MAC: one broadcast activation times LANES weights per beat,
// requantised on vector completion. Optional MAC_LANES_ROUNDING_EN: round-half-up.
module mac_lanes #(
    parameter int WIDTH   = 8,
    parameter int LANES   = 4,
    parameter int MAX_ACC = 16,
    parameter int SHIFT_W = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             clear,
    input  logic [$clog2(MAX_ACC+1)-1:0]     acc_len,
    input  logic [SHIFT_W-1:0]               shift,
    input  logic                             relu_en,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [WIDTH-1:0]                 a,
    input  logic [LANES*WIDTH-1:0]           b,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [LANES*WIDTH-1:0]           out,
    output logic                             busy
);

    localparam int LEN_W = $clog2(MAX_ACC + 1);
    localparam int ACC_W = 2 * WIDTH + $clog2(MAX_ACC);
    localparam int PRD_W = 2 * WIDTH;

    localparam logic signed [ACC_W:0] MAXV = (ACC_W+1)'((2 ** (WIDTH - 1)) - 1);
    localparam logic signed [ACC_W:0] MINV = (ACC_W+1)'(-(2 ** (WIDTH - 1)));

    typedef enum logic {ST_ACC, ST_DONE} state_t;

    state_t                         state_q, state_d;
    logic [LEN_W-1:0]               cnt_q, cnt_d;
    logic [LEN_W-1:0]               len_q, len_d;
    logic [SHIFT_W-1:0]             shift_q, shift_d;
    logic                           relu_q, relu_d;
    logic [LANES-1:0][ACC_W-1:0]    acc_q, acc_d;
    logic [LANES*WIDTH-1:0]         out_q, out_d;

    logic                           beat;
    logic                           first;
    logic                           last;
    logic [LEN_W-1:0]               len_clamp;
    logic [LEN_W-1:0]               len_eff;
    logic [SHIFT_W-1:0]             shift_eff;
    logic                           relu_eff;
    logic [LANES-1:0][PRD_W-1:0]    prod;
    logic [LANES-1:0][ACC_W-1:0]    sum;

    // Shift, optional rounding, saturate to WIDTH, then ReLU.
    function automatic logic [WIDTH-1:0] requant(
        input logic signed [ACC_W-1:0] s,
        input logic [SHIFT_W-1:0]      sh,
        input logic                    relu
    );
        logic signed [ACC_W:0] ext;
        logic signed [ACC_W:0] shd;
        logic [WIDTH-1:0]      res;
        ext = (ACC_W+1)'(s);
`ifdef MAC_LANES_ROUNDING_EN
        if (sh != '0 && int'(sh) < ACC_W) begin
            ext = ext + ((ACC_W+1)'(1) <<< (int'(sh) - 1));
        end
`endif
        shd = ext >>> sh;
        if (shd > MAXV) begin
            res = MAXV[WIDTH-1:0];
        end else if (shd < MINV) begin
            res = MINV[WIDTH-1:0];
        end else begin
            res = shd[WIDTH-1:0];
        end
        if (relu && res[WIDTH-1]) begin
            res = '0;
        end
        return res;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_ACC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_ACC;
        end else begin
            unique case (state_q)
                ST_ACC:  if (beat && last) state_d = ST_DONE;
                ST_DONE: if (out_ready)    state_d = ST_ACC;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state_q == ST_ACC);
        out_valid = (state_q == ST_DONE);
        busy      = (cnt_q != '0) || (state_q == ST_DONE);
        out       = out_q;
    end

    always_comb begin
        len_clamp = acc_len;
        if (acc_len == '0) begin
            len_clamp = LEN_W'(1);
        end else if (acc_len > LEN_W'(MAX_ACC)) begin
            len_clamp = LEN_W'(MAX_ACC);
        end
    end

    // Controls come from the ports on the first beat, from the latches afterwards.
    always_comb begin
        beat      = in_valid && in_ready;
        first     = (cnt_q == '0);
        len_eff   = first ? len_clamp : len_q;
        shift_eff = first ? shift : shift_q;
        relu_eff  = first ? relu_en : relu_q;
        last      = (cnt_q == len_eff - LEN_W'(1));
        for (int i = 0; i < LANES; i++) begin
            prod[i] = PRD_W'($signed(a)) * PRD_W'($signed(b[i*WIDTH +: WIDTH]));
            sum[i]  = acc_q[i] + ACC_W'($signed(prod[i]));
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        len_d   = len_q;
        shift_d = shift_q;
        relu_d  = relu_q;
        acc_d   = acc_q;
        out_d   = out_q;
        if (clear) begin
            cnt_d = '0;
            acc_d = '0;
        end else if (out_valid && out_ready) begin
            acc_d = '0;
        end else if (beat) begin
            len_d   = len_eff;
            shift_d = shift_eff;
            relu_d  = relu_eff;
            cnt_d   = last ? '0 : cnt_q + LEN_W'(1);
            acc_d   = sum;
            if (last) begin
                for (int i = 0; i < LANES; i++) begin
                    out_d[i*WIDTH +: WIDTH] = requant(sum[i], shift_eff, relu_eff);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            len_q   <= '0;
            shift_q <= '0;
            relu_q  <= 1'b0;
            acc_q   <= '0;
            out_q   <= '0;
        end else begin
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            shift_q <= shift_d;
            relu_q  <= relu_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
        end
    end

endmodule
